// File: rtl/onehot_priority_encoder_if.sv
// Signal bundle for the one-hot encoder: the input select vector and every result it produces.
// master drives the select vector; slave is the encoder side.
interface onehot_priority_encoder_if #(
  parameter int decode_width = 16,
  parameter int encode_width = $clog2(decode_width)
);
  logic [decode_width-1:0] in;
  logic [encode_width-1:0] out;
  logic                    valid;
  logic                    multi_hot;
  logic [encode_width-1:0] out_q;
  logic                    valid_q;
  logic                    multi_hot_q;
  logic                    err_sticky;

  modport master (
    output in,
    input  out, valid, multi_hot, out_q, valid_q, multi_hot_q, err_sticky
  );
  modport slave (
    input  in,
    output out, valid, multi_hot, out_q, valid_q, multi_hot_q, err_sticky
  );
endinterface

// File: rtl/onehot_priority_encoder.sv
// One-hot to binary encoder with MSB-first priority.
// Provides combinational results, one registered copy of them, and a sticky quality flag.
module onehot_priority_encoder #(
  parameter int decode_width = 16,
  parameter int encode_width = $clog2(decode_width)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [decode_width-1:0] in,
  output logic [encode_width-1:0] out,
  output logic                    valid,
  output logic                    multi_hot,
  output logic [encode_width-1:0] out_q,
  output logic                    valid_q,
  output logic                    multi_hot_q,
  output logic                    err_sticky
);

  generate
    if (decode_width < 2) begin : g_chk_min
      $error("decode_width must be at least 2");
    end
    if ((decode_width - 1) >= (1 << encode_width)) begin : g_chk_fit
      $error("encode_width too narrow for index decode_width-1");
    end
  endgenerate

  localparam logic [decode_width-1:0] ONE = decode_width'(1);

  // The scan runs upward, so the last set bit it sees is the highest one.
  always_comb begin
    out = '0;
    for (int i = 0; i < decode_width; i++)
      if (in[i]) out = encode_width'(i);
  end

  assign valid     = |in;
  assign multi_hot = |(in & (in - ONE));

  // Valid pipeline: element 0 is the live flag, element 1 its registered copy.
  logic [1:0] vld_pipe;
  assign vld_pipe[0] = valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[1] <= 1'b0;
      out_q       <= '0;
      multi_hot_q <= 1'b0;
      err_sticky  <= 1'b0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      out_q       <= out;
      multi_hot_q <= multi_hot;
      err_sticky  <= err_sticky | ~valid | multi_hot;
    end
  end

  assign valid_q = vld_pipe[1];

endmodule

// File: tb/tb_onehot_priority_encoder.sv
// Directed bench for onehot_priority_encoder: 16-bit instance plus a 5-bit non-power-of-two instance.
module tb_onehot_priority_encoder;
  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  onehot_priority_encoder_if #(16, 4) ifc ();
  onehot_priority_encoder_if #(5, 3)  ifc5 ();

  onehot_priority_encoder #(16, 4) dut (
    .clk(clk), .rst_n(rst_n), .in(ifc.in), .out(ifc.out), .valid(ifc.valid),
    .multi_hot(ifc.multi_hot), .out_q(ifc.out_q), .valid_q(ifc.valid_q),
    .multi_hot_q(ifc.multi_hot_q), .err_sticky(ifc.err_sticky)
  );

  onehot_priority_encoder #(5, 3) dut5 (
    .clk(clk), .rst_n(rst_n), .in(ifc5.in), .out(ifc5.out), .valid(ifc5.valid),
    .multi_hot(ifc5.multi_hot), .out_q(ifc5.out_q), .valid_q(ifc5.valid_q),
    .multi_hot_q(ifc5.multi_hot_q), .err_sticky(ifc5.err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ifc.in = 16'h0001;
    ifc5.in = 5'b00001;
    @(posedge clk); #1;
    total_cnt++; if (ifc.out_q !== 4'd0) $display("FAIL reset_out_q got %0d want 0", ifc.out_q); else pass_cnt++;
    total_cnt++; if (ifc.valid_q !== 1'b0) $display("FAIL reset_valid_q got %b want 0", ifc.valid_q); else pass_cnt++;
    total_cnt++; if (ifc.multi_hot_q !== 1'b0) $display("FAIL reset_multi_hot_q got %b want 0", ifc.multi_hot_q); else pass_cnt++;
    total_cnt++; if (ifc.err_sticky !== 1'b0) $display("FAIL reset_err got %b want 0", ifc.err_sticky); else pass_cnt++;
    total_cnt++; if (ifc.out !== 4'd0 || ifc.valid !== 1'b1) $display("FAIL reset_comb out=%0d valid=%b want 0/1", ifc.out, ifc.valid); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_walk();
    logic [3:0] exp;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ifc.in = 16'h0001 << i;
      exp = 4'(i);
      #1;
      total_cnt++;
      if (ifc.out !== exp || ifc.valid !== 1'b1 || ifc.multi_hot !== 1'b0)
        $display("FAIL walk_comb i=%0d got out=%0d v=%b m=%b want %0d/1/0", i, ifc.out, ifc.valid, ifc.multi_hot, exp);
      else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++;
      if (ifc.out_q !== exp || ifc.valid_q !== 1'b1)
        $display("FAIL walk_q i=%0d got out_q=%0d vq=%b want %0d/1", i, ifc.out_q, ifc.valid_q, exp);
      else pass_cnt++;
    end
    total_cnt++; if (ifc.err_sticky !== 1'b0) $display("FAIL walk_err got %b want 0", ifc.err_sticky); else pass_cnt++;
  endtask

  task automatic test_zero();
    @(negedge clk);
    ifc.in = 16'h0000;
    #1;
    total_cnt++; if (ifc.out !== 4'd0 || ifc.valid !== 1'b0) $display("FAIL zero_comb got out=%0d v=%b want 0/0", ifc.out, ifc.valid); else pass_cnt++;
    total_cnt++; if (ifc.err_sticky !== 1'b0) $display("FAIL zero_err_pre got %b want 0", ifc.err_sticky); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (ifc.valid_q !== 1'b0) $display("FAIL zero_valid_q got %b want 0", ifc.valid_q); else pass_cnt++;
    total_cnt++; if (ifc.err_sticky !== 1'b1) $display("FAIL zero_err got %b want 1", ifc.err_sticky); else pass_cnt++;
  endtask

  task automatic test_multi();
    // clear the sticky flag from the zero test
    @(negedge clk);
    ifc.in = 16'h0002;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
    total_cnt++; if (ifc.err_sticky !== 1'b0) $display("FAIL multi_clear got %b want 0", ifc.err_sticky); else pass_cnt++;
    ifc.in = 16'h8001;
    #1;
    total_cnt++;
    if (ifc.out !== 4'd15 || ifc.multi_hot !== 1'b1 || ifc.valid !== 1'b1)
      $display("FAIL multi_8001 got out=%0d m=%b v=%b want 15/1/1", ifc.out, ifc.multi_hot, ifc.valid);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (ifc.err_sticky !== 1'b1) $display("FAIL multi_err got %b want 1", ifc.err_sticky); else pass_cnt++;
    total_cnt++; if (ifc.multi_hot_q !== 1'b1 || ifc.out_q !== 4'd15) $display("FAIL multi_q got mq=%b oq=%0d want 1/15", ifc.multi_hot_q, ifc.out_q); else pass_cnt++;
    @(negedge clk);
    ifc.in = 16'h0006;
    #1;
    total_cnt++; if (ifc.out !== 4'd2 || ifc.multi_hot !== 1'b1) $display("FAIL multi_0006 got out=%0d m=%b want 2/1", ifc.out, ifc.multi_hot); else pass_cnt++;
    @(negedge clk);
    ifc.in = 16'h0001;
    @(posedge clk); #1;
    total_cnt++; if (ifc.err_sticky !== 1'b1) $display("FAIL multi_err_hold got %b want 1", ifc.err_sticky); else pass_cnt++;
    total_cnt++; if (ifc.multi_hot_q !== 1'b0) $display("FAIL multi_q_clear got %b want 0", ifc.multi_hot_q); else pass_cnt++;
  endtask

  task automatic test_latency();
    @(negedge clk);
    ifc.in = 16'h0010;
    @(posedge clk); #1;
    total_cnt++; if (ifc.out_q !== 4'd4 || ifc.valid_q !== 1'b1) $display("FAIL lat_first got oq=%0d vq=%b want 4/1", ifc.out_q, ifc.valid_q); else pass_cnt++;
    @(negedge clk);
    ifc.in = 16'h0100;
    #1;
    total_cnt++; if (ifc.out_q !== 4'd4) $display("FAIL lat_hold got %0d want 4", ifc.out_q); else pass_cnt++;
    total_cnt++; if (ifc.out !== 4'd8) $display("FAIL lat_comb got %0d want 8", ifc.out); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (ifc.out_q !== 4'd8) $display("FAIL lat_next got %0d want 8", ifc.out_q); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    total_cnt++; if (ifc.err_sticky !== 1'b1 || ifc.out_q !== 4'd8) $display("FAIL ar_pre got err=%b oq=%0d want 1/8", ifc.err_sticky, ifc.out_q); else pass_cnt++;
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (ifc.out_q !== 4'd0 || ifc.valid_q !== 1'b0 || ifc.multi_hot_q !== 1'b0 || ifc.err_sticky !== 1'b0)
      $display("FAIL ar_clear got oq=%0d vq=%b mq=%b err=%b want 0/0/0/0", ifc.out_q, ifc.valid_q, ifc.multi_hot_q, ifc.err_sticky);
    else pass_cnt++;
    total_cnt++; if (ifc.out !== 4'd8) $display("FAIL ar_comb got %0d want 8", ifc.out); else pass_cnt++;
    ifc.in = 16'h0020;
    #1;
    total_cnt++; if (ifc.out !== 4'd5 || ifc.valid !== 1'b1) $display("FAIL ar_track got out=%0d v=%b want 5/1", ifc.out, ifc.valid); else pass_cnt++;
    rst_n = 1'b1;
    #1;
    total_cnt++; if (ifc.out_q !== 4'd0) $display("FAIL ar_release got %0d want 0", ifc.out_q); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (ifc.out_q !== 4'd5 || ifc.valid_q !== 1'b1 || ifc.err_sticky !== 1'b0)
      $display("FAIL ar_capture got oq=%0d vq=%b err=%b want 5/1/0", ifc.out_q, ifc.valid_q, ifc.err_sticky);
    else pass_cnt++;
  endtask

  task automatic test_np2();
    logic [2:0] exp;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ifc5.in = 5'b00001 << i;
      exp = 3'(i);
      #1;
      total_cnt++;
      if (ifc5.out !== exp || ifc5.valid !== 1'b1 || ifc5.multi_hot !== 1'b0)
        $display("FAIL np2_walk i=%0d got out=%0d v=%b m=%b want %0d/1/0", i, ifc5.out, ifc5.valid, ifc5.multi_hot, exp);
      else pass_cnt++;
    end
    @(negedge clk);
    ifc5.in = 5'b11111;
    #1;
    total_cnt++; if (ifc5.out !== 3'd4 || ifc5.multi_hot !== 1'b1) $display("FAIL np2_all got out=%0d m=%b want 4/1", ifc5.out, ifc5.multi_hot); else pass_cnt++;
    ifc5.in = 5'b00000;
    #1;
    total_cnt++; if (ifc5.out !== 3'd0 || ifc5.valid !== 1'b0) $display("FAIL np2_zero got out=%0d v=%b want 0/0", ifc5.out, ifc5.valid); else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n     = 1'b0;
    ifc.in    = '0;
    ifc5.in   = '0;
    test_reset();
    test_walk();
    test_zero();
    test_multi();
    test_latency();
    test_async_reset();
    test_np2();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
